// File: rtl/decode_issue_controller_pkg.sv
// rtl/decode_issue_controller_pkg.sv - shared widths, immediate formats and opcodes for decode issue
package decode_issue_controller_pkg;

    localparam int BIT_COUNT = 32;
    localparam int WORD_SIZE = 32;
    localparam int DEPTH     = 2;

    typedef enum logic [2:0] {
        Imm11t0 = 3'd0,
        Imm4t0  = 3'd1,
        SType   = 3'd2,
        BType   = 3'd3,
        UType   = 3'd4,
        JType   = 3'd5
    } imm_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [BIT_COUNT-1:0] pc;
        imm_src_e             imm_src;
        logic                 imm_used;
        logic                 illegal;
    } entry_t;

endpackage

// File: rtl/decode_issue_controller_imm_format_decode.sv
// rtl/decode_issue_controller_imm_format_decode.sv - maps an instruction to its immediate format
module imm_format_decode
    import decode_issue_controller_pkg::*;
(
    input  logic [WORD_SIZE-1:0] instr,
    output imm_src_e             imm_src,
    output logic                 imm_used,
    output logic                 illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Shift-immediate OP-IMM forms only use a 5-bit shamt; R-type is legal but carries no immediate
    always_comb begin
        imm_src  = Imm11t0;
        imm_used = 1'b1;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: imm_src = Imm11t0;
            OP_IMM:           imm_src = (funct3 == 3'b001 || funct3 == 3'b101) ? Imm4t0 : Imm11t0;
            OP_STORE:         imm_src = SType;
            OP_BRANCH:        imm_src = BType;
            OP_LUI, OP_AUIPC: imm_src = UType;
            OP_JAL:           imm_src = JType;
            OP_REG:           imm_used = 1'b0;
            default: begin
                imm_used = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_issue_controller.sv
// rtl/decode_issue_controller.sv - 2-entry skid FIFO between fetch and execute with enqueue-time imm decode
module decode_issue_controller
    import decode_issue_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 FlushD,
    input  logic                 ValidF,
    input  logic [WORD_SIZE-1:0] InstrF,
    input  logic [BIT_COUNT-1:0] PCF,
    output logic                 ReadyF,
    output logic                 ValidD,
    input  logic                 ReadyE,
    output logic [WORD_SIZE-1:0] InstrD,
    output logic [BIT_COUNT-1:0] PCD,
    output imm_src_e             ImmSrcD,
    output logic                 ImmUsedD,
    output logic                 IllegalD
);

    entry_t     mem_q [DEPTH];
    entry_t     mem_d [DEPTH];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;

    entry_t     dec_entry;
    imm_src_e   dec_imm_src;
    logic       dec_imm_used;
    logic       dec_illegal;
    logic       enq;
    logic       deq;

    imm_format_decode u_imm_format_decode (
        .instr    (InstrF),
        .imm_src  (dec_imm_src),
        .imm_used (dec_imm_used),
        .illegal  (dec_illegal)
    );

    assign dec_entry = '{instr: InstrF, pc: PCF, imm_src: dec_imm_src,
                         imm_used: dec_imm_used, illegal: dec_illegal};

    // Handshakes look only at registered count, so there is no fetch-to-execute pass-through
    assign ReadyF = (count_q != 2'd2);
    assign ValidD = (count_q != 2'd0);
    assign enq    = ValidF & ReadyF & ~FlushD;
    assign deq    = ValidD & ReadyE;

    assign InstrD   = mem_q[head_q].instr;
    assign PCD      = mem_q[head_q].pc;
    assign ImmSrcD  = mem_q[head_q].imm_src;
    assign ImmUsedD = mem_q[head_q].imm_used;
    assign IllegalD = mem_q[head_q].illegal;

    // Next pointer/count/storage; flush empties the queue and wins over any enqueue
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            mem_d[tail_q] = dec_entry;
        end
        if (FlushD) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            head_d  = head_q ^ deq;
            tail_d  = tail_q ^ enq;
            count_d = count_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset; it is only meaningful while ValidD is high
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_decode_issue_controller.sv
// tb/tb_decode_issue_controller.sv - directed self-checking bench for decode_issue_controller
module tb_decode_issue_controller;
    import decode_issue_controller_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 FlushD;
    logic                 ValidF;
    logic [WORD_SIZE-1:0] InstrF;
    logic [BIT_COUNT-1:0] PCF;
    logic                 ReadyF;
    logic                 ValidD;
    logic                 ReadyE;
    logic [WORD_SIZE-1:0] InstrD;
    logic [BIT_COUNT-1:0] PCD;
    imm_src_e             ImmSrcD;
    logic                 ImmUsedD;
    logic                 IllegalD;

    int checks = 0;
    int errors = 0;

    decode_issue_controller dut (
        .clk      (clk),
        .reset    (reset),
        .FlushD   (FlushD),
        .ValidF   (ValidF),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .ReadyF   (ReadyF),
        .ValidD   (ValidD),
        .ReadyE   (ReadyE),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .ImmSrcD  (ImmSrcD),
        .ImmUsedD (ImmUsedD),
        .IllegalD (IllegalD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] stream_instr [6];
    imm_src_e    stream_src   [6];

    initial begin
        stream_instr[0] = 32'h00500093; stream_src[0] = Imm11t0;
        stream_instr[1] = 32'h00309093; stream_src[1] = Imm4t0;
        stream_instr[2] = 32'h0020A423; stream_src[2] = SType;
        stream_instr[3] = 32'h00208463; stream_src[3] = BType;
        stream_instr[4] = 32'h12345037; stream_src[4] = UType;
        stream_instr[5] = 32'h008000EF; stream_src[5] = JType;

        reset = 1'b0; FlushD = 1'b0; ValidF = 1'b0; ReadyE = 1'b0;
        InstrF = '0; PCF = '0;
        tick();
        tick();
        chk("reset_validd", ValidD, 1'b0);
        chk("reset_readyf", ReadyF, 1'b1);
        reset = 1'b1;
        tick();
        chk("idle_validd", ValidD, 1'b0);

        // Streaming at full rate: each instruction is at the head the cycle after its enqueue
        ReadyE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ValidF = 1'b1; InstrF = stream_instr[i]; PCF = 32'h100 + 32'(4 * i);
            tick();
            chk($sformatf("stream%0d_validd", i), ValidD, 1'b1);
            chk($sformatf("stream%0d_readyf", i), ReadyF, 1'b1);
            chk($sformatf("stream%0d_instr", i), InstrD, stream_instr[i]);
            chk($sformatf("stream%0d_pc", i), PCD, 32'h100 + 32'(4 * i));
            chk($sformatf("stream%0d_immsrc", i), ImmSrcD, stream_src[i]);
            chk($sformatf("stream%0d_immused", i), ImmUsedD, 1'b1);
            chk($sformatf("stream%0d_illegal", i), IllegalD, 1'b0);
        end

        InstrF = 32'h002081B3; PCF = 32'h200;
        tick();
        chk("rtype_instr", InstrD, 32'h002081B3);
        chk("rtype_immused", ImmUsedD, 1'b0);
        chk("rtype_illegal", IllegalD, 1'b0);
        chk("rtype_immsrc", ImmSrcD, Imm11t0);
        InstrF = 32'h0000007F; PCF = 32'h204;
        tick();
        chk("illegal_instr", InstrD, 32'h0000007F);
        chk("illegal_flag", IllegalD, 1'b1);
        chk("illegal_immused", ImmUsedD, 1'b0);
        ValidF = 1'b0;
        tick();
        chk("drain_validd", ValidD, 1'b0);

        // Back-pressure: two accepts fill the queue, third waits at fetch
        ReadyE = 1'b0;
        ValidF = 1'b1; InstrF = 32'h00100113; PCF = 32'h300;
        tick();
        chk("stall_a_readyf", ReadyF, 1'b1);
        chk("stall_a_instr", InstrD, 32'h00100113);
        InstrF = 32'h00200193; PCF = 32'h304;
        tick();
        chk("stall_full_readyf", ReadyF, 1'b0);
        chk("stall_b_instr", InstrD, 32'h00100113);
        InstrF = 32'h00300213; PCF = 32'h308;
        tick();
        chk("stall_hold1_readyf", ReadyF, 1'b0);
        chk("stall_hold1_instr", InstrD, 32'h00100113);
        tick();
        chk("stall_hold2_instr", InstrD, 32'h00100113);
        chk("stall_hold2_pc", PCD, 32'h300);
        ReadyE = 1'b1;
        tick();
        chk("release_b_instr", InstrD, 32'h00200193);
        chk("release_readyf", ReadyF, 1'b1);
        tick();
        chk("release_c_instr", InstrD, 32'h00300213);
        chk("release_c_validd", ValidD, 1'b1);
        ValidF = 1'b0;
        tick();
        chk("release_empty", ValidD, 1'b0);

        // Flush at full with an incoming instruction
        ReadyE = 1'b0;
        ValidF = 1'b1; InstrF = 32'h00400293; PCF = 32'h400;
        tick();
        InstrF = 32'h00500313; PCF = 32'h404;
        tick();
        chk("flush_pre_full", ReadyF, 1'b0);
        InstrF = 32'h00600393; PCF = 32'h408; FlushD = 1'b1;
        tick();
        chk("flush_validd", ValidD, 1'b0);
        chk("flush_readyf", ReadyF, 1'b1);
        FlushD = 1'b0; ReadyE = 1'b1;
        InstrF = 32'h00700413; PCF = 32'h40C;
        tick();
        chk("flush_next_instr", InstrD, 32'h00700413);
        ValidF = 1'b0;
        tick();
        chk("flush_next_empty", ValidD, 1'b0);

        // Flush drops a same-cycle enqueue when there is room for it
        ReadyE = 1'b0;
        ValidF = 1'b1; InstrF = 32'h00800493; PCF = 32'h410;
        tick();
        InstrF = 32'h00900513; PCF = 32'h414; FlushD = 1'b1;
        tick();
        chk("flush_drop_validd", ValidD, 1'b0);
        FlushD = 1'b0; ValidF = 1'b0;
        tick();
        chk("flush_drop_stays_empty", ValidD, 1'b0);

        // Steady state at count 1: simultaneous enqueue and dequeue, pointers wrap
        ReadyE = 1'b1;
        ValidF = 1'b1; InstrF = 32'h00000013; PCF = 32'h500;
        tick();
        chk("wrap_start_pc", PCD, 32'h500);
        for (int k = 1; k <= 5; k++) begin
            PCF = 32'h500 + 32'(4 * k);
            tick();
            chk($sformatf("wrap%0d_pc", k), PCD, 32'h500 + 32'(4 * k));
            chk($sformatf("wrap%0d_validd", k), ValidD, 1'b1);
            chk($sformatf("wrap%0d_readyf", k), ReadyF, 1'b1);
        end
        ValidF = 1'b0;
        tick();
        chk("wrap_empty", ValidD, 1'b0);

        // Mid-operation reset while full and stalled
        ReadyE = 1'b0;
        ValidF = 1'b1; InstrF = 32'h00A00593; PCF = 32'h600;
        tick();
        InstrF = 32'h00B00613; PCF = 32'h604;
        tick();
        chk("rst_pre_full", ReadyF, 1'b0);
        reset = 1'b0; ValidF = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_mid_validd", ValidD, 1'b0);
        chk("rst_mid_readyf", ReadyF, 1'b1);
        ReadyE = 1'b1;
        ValidF = 1'b1; InstrF = 32'h00C00693; PCF = 32'h700;
        tick();
        chk("rst_next_instr", InstrD, 32'h00C00693);
        chk("rst_next_pc", PCD, 32'h700);
        ValidF = 1'b0;
        tick();
        chk("rst_next_empty", ValidD, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_controller.md
Name: decode_issue_controller

Overview:
- Decode-stage front end that sequences the immediate extender.
- Accepts fetched instructions over a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Decodes each opcode/funct3 into the immSrc selection at enqueue, so the extender gets a registered, stable ImmSrc alongside its Instr.
- Presents the head entry to the execute stage over a second valid/ready handshake. Handles flush and back-pressure.

Parameters:
- DEPTH, 2, FIFO entries; fixed at 2 for this revision, other values unsupported.
- BIT_COUNT and WORD_SIZE come from the shared parameters header, not module parameters.

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-low reset
- FlushD  input  1  squash all buffered and incoming instructions this cycle
- ValidF  input  1  fetch presents InstrF/PCF
- InstrF  input  WORD_SIZE  fetched instruction
- PCF  input  BIT_COUNT  PC of InstrF
- ReadyF  output  1  controller can accept this cycle
- ValidD  output  1  head entry valid toward execute
- ReadyE  input  1  execute accepts head this cycle
- InstrD  output  WORD_SIZE  head instruction, wired to the extender's Instr input
- PCD  output  BIT_COUNT  head PC
- ImmSrcD  output  immSrc  head immediate format, wired to the extender's ImmSrc input
- ImmUsedD  output  1  head instruction carries an immediate
- IllegalD  output  1  head opcode not recognised

Behaviour:
- State
  - Entries 0..1 hold {Instr, PC, ImmSrc, ImmUsed, Illegal}, plus a head pointer, a tail pointer and a 2-bit count (0..2).
- Handshakes
  - Enqueue when ValidF & ReadyF. Dequeue when ValidD & ReadyE.
  - ReadyF = (count != 2), driven combinationally from registered count only; no dependence on ReadyE (no pass-through).
  - ValidD = (count != 0).
  - All D outputs come straight from head-entry storage, with no combinational path from F inputs.
- Latency
  - Instruction enqueued in cycle N appears at ValidD in cycle N+1 at the earliest.
  - Throughput is 1 instruction/cycle while ReadyE stays high.
- Simultaneous events
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance (wrap modulo 2).
  - At count==2 enqueue cannot occur, so a dequeue reduces count to 1.
- Flush
  - FlushD high: count, head and tail go to 0 at the next edge.
  - A same-cycle enqueue is dropped. A same-cycle dequeue still completes on the execute side; its outputs were valid that cycle.
  - FlushD has priority over enqueue.
- Reset
  - While reset is low at a rising edge: count=0, head=tail=0.
  - So after that edge ValidD=0 and ReadyF=1. This holds when reset is asserted mid-operation; buffered entries are lost.
  - Entry payloads are not reset. InstrD/PCD/ImmSrcD/ImmUsedD/IllegalD are don't-care while ValidD=0, and the bench checks them only when ValidD=1.
- Decode at enqueue (opcode = Instr[6:0])
  - 0000011 load, 1100111 JALR: Imm11t0.
  - 0010011 OP-IMM with funct3 001 or 101: Imm4t0. Other funct3 values: Imm11t0.
  - 0100011: SType.
  - 1100011: BType.
  - 0110111 LUI, 0010111 AUIPC: UType.
  - 1101111: JType.
  - For all of the above: ImmUsed=1, Illegal=0.
  - 0110011 R-type: ImmUsed=0, Illegal=0, ImmSrc=Imm11t0 (benign).
  - Any other opcode: ImmUsed=0, Illegal=1, ImmSrc=Imm11t0.
- Held outputs
  - While ValidD=1 and ReadyE=0, all D outputs hold stable.

Decomposition:
- The immSrc enum already lives in the HighLevelControl package.
- Add opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG) to the same package.
- One natural sub-module: imm_format_decode. Purely combinational, maps Instr to {ImmSrc, ImmUsed, Illegal}, instantiated on the enqueue path.

Test Plan:
- Reset, then stream 0x00500093, 0x00309093, 0x0020A423, 0x00208463, 0x12345037, 0x008000EF with ReadyE=1 -> ValidD from cycle after first enqueue. ImmSrcD sequence Imm11t0, Imm4t0, SType, BType, UType, JType; ImmUsedD=1 throughout; one instruction per cycle.
- Enqueue 0x002081B3 (add) -> ImmUsedD=0, IllegalD=0. Enqueue 0x0000007F -> IllegalD=1.
- ReadyE=0, push 3 instructions -> ReadyF drops to 0 after 2 accepts, the third is held at fetch. Head InstrD is stable for the whole stall. Raise ReadyE -> order preserved and the third is accepted the cycle count drops to 1.
- Count=2 with ValidF=1 and FlushD=1 -> next cycle ValidD=0, ReadyF=1, and the incoming instruction does not appear later.
- Count=1, simultaneous enqueue and dequeue repeated 5 cycles -> count stays 1, pointers wrap, PCD increments by 4 each cycle.
- Drive reset low for one edge while count=2 and ReadyE=0 -> ValidD=0, ReadyF=1 the following cycle, and the next accepted instruction emerges first.
